ifetch_unit: RTL and testbench

Instruction fetch sequencer that owns the architectural PC register and drives instruction memory over a request/acknowledge handshake. Each fetched word is presented to decode together with `pc_output` and `pc_inc`. The PC control logic returns `pc_next` and `hlt`, and the fetch unit commits that value when decode accepts the instruction. The block sits between the PC register file boundary and instruction memory, and absorbs variable memory latency and decode back-pressure.

---
 rtl/ifetch_unit.sv | 113 +++++++++++
 tb/tb_ifetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch sequencer: PC register, memory request/ack, decode handoff
module ifetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    input  logic        dec_ready,
    output logic [15:0] pc_output,
    output logic [15:0] pc_inc,
    input  logic [15:0] pc_next,
    input  logic        hlt,
    output logic        halted,
    output logic        err_timeout,
    output logic        err_misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] pc, pc_d;
    logic [15:0] instr_d;
    logic [7:0]  wait_cnt, wait_cnt_d;
    logic        err_timeout_d, err_misalign_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_d           = pc;
        instr_d        = instr_out;
        wait_cnt_d     = wait_cnt;
        err_timeout_d  = err_timeout;
        err_misalign_d = err_misalign;
        case (state)
            IDLE: begin
                state_nxt  = FETCH;
                wait_cnt_d = 8'd0;
            end
            FETCH: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if (mem_ack) begin
                    instr_d    = mem_rdata;
                    wait_cnt_d = 8'd0;
                    state_nxt  = HOLD;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_timeout_d = 1'b1;
                    state_nxt     = HALT;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (dec_ready) begin
                    if (hlt) begin
                        state_nxt = HALT;
                    end else begin
                        pc_d           = {pc_next[15:1], 1'b0};
                        err_misalign_d = err_misalign | pc_next[0];
                        wait_cnt_d     = 8'd0;
                        state_nxt      = FETCH;
                    end
                end
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            instr_out    <= 16'h0000;
            wait_cnt     <= 8'd0;
            err_timeout  <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            pc           <= pc_d;
            instr_out    <= instr_d;
            wait_cnt     <= wait_cnt_d;
            err_timeout  <= err_timeout_d;
            err_misalign <= err_misalign_d;
        end
    end

    assign mem_req     = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign halted      = (state == HALT);
    assign mem_addr    = pc;
    assign pc_output   = pc;
    assign pc_inc      = pc + 16'd2;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed and randomized bench for ifetch_unit against a flag-based reference model
module tb_ifetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          TIMEOUT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'h0000;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        dec_ready = 1'b0;
    logic [15:0] pc_output;
    logic [15:0] pc_inc;
    logic [15:0] pc_next = 16'h0000;
    logic        hlt = 1'b0;
    logic        halted;
    logic        err_timeout;
    logic        err_misalign;

    always #5 clk = ~clk;

    ifetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_out(instr_out), .instr_valid(instr_valid), .dec_ready(dec_ready),
        .pc_output(pc_output), .pc_inc(pc_inc), .pc_next(pc_next), .hlt(hlt),
        .halted(halted), .err_timeout(err_timeout), .err_misalign(err_misalign)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: what the fetcher is currently doing, as independent flags.
    bit          m_started, m_req, m_valid, m_halted, m_eto, m_emis;
    logic [15:0] m_pc, m_instr;
    int          m_misses;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_started = 0; m_req = 0; m_valid = 0; m_halted = 0; m_eto = 0; m_emis = 0;
        m_pc = RESET_PC; m_instr = 16'h0000; m_misses = 0;
    endfunction

    function automatic void model_step();
        if (rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1; m_req = 1; m_misses = 0;
        end else if (m_req) begin
            if (mem_ack) begin
                m_instr = mem_rdata; m_req = 0; m_valid = 1;
            end else if (m_misses + 1 == TIMEOUT) begin
                m_eto = 1; m_req = 0; m_halted = 1;
            end else begin
                m_misses++;
            end
        end else if (m_valid && dec_ready) begin
            m_valid = 0;
            if (hlt) begin
                m_halted = 1;
            end else begin
                m_pc = pc_next & 16'hFFFE;
                if (pc_next[0]) m_emis = 1;
                m_req = 1; m_misses = 0;
            end
        end
    endfunction

    task automatic compare_all();
        check("mem_req", 32'(mem_req), 32'(m_req));
        check("mem_addr", 32'(mem_addr), 32'(m_pc));
        check("pc_output", 32'(pc_output), 32'(m_pc));
        check("pc_inc", 32'(pc_inc), 32'((m_pc + 32'd2) % 32'h10000));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("instr_out", 32'(instr_out), 32'(m_instr));
        check("halted", 32'(halted), 32'(m_halted));
        check("err_timeout", 32'(err_timeout), 32'(m_eto));
        check("err_misalign", 32'(err_misalign), 32'(m_emis));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic step(input logic ack, input logic [15:0] rdata, input logic ready,
                        input logic h, input logic [15:0] pn);
        mem_ack = ack; mem_rdata = rdata; dec_ready = ready; hlt = h; pc_next = pn;
        cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (n) cycle();
        rst = 1'b0;
    endtask

    // Caller must be in a fetch cycle: zero-wait fetch of rdata, then an accepting decode.
    task automatic fetch_commit(input logic [15:0] rdata, input logic [15:0] pn, input logic h);
        step(1'b1, rdata, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 16'h0000, 1'b1, h, pn);
    endtask

    int          req_cnt;
    logic [15:0] word, pc_hold;

    initial begin
        #2;
        // Reset and zero-wait fetch
        do_reset(3);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 16'($urandom), 1'b1, 1'b0, 16'(m_pc + 16'd2));
            check("zw_req_cadence", 32'(mem_req), 32'(i % 2 == 0));
            if (i % 2 == 0) check("zw_addr", 32'(mem_addr), 32'(i));
        end

        // Wait states and decode stall
        do_reset(1);
        req_cnt = 0;
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        req_cnt += int'(mem_req);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234);
            req_cnt += int'(mem_req);
        end
        word = 16'hA5C3;
        step(1'b1, word, 1'b0, 1'b0, 16'h0000);
        req_cnt += int'(mem_req);
        check("ws_req_cycles", 32'(req_cnt), 32'd4);
        pc_hold = RESET_PC;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h5555, 1'b0, 1'b1, 16'h0777);
            check("stall_instr", 32'(instr_out), 32'(word));
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_pc", 32'(pc_output), 32'(pc_hold));
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, 16'(m_pc + 16'd2));
        check("accept_addr", 32'(mem_addr), 32'(RESET_PC + 16'd2));

        // Branch, misalign and wrap
        fetch_commit(16'h1111, 16'h0010, 1'b0);
        fetch_commit(16'h2222, 16'h0041, 1'b0);
        check("branch_addr", 32'(mem_addr), 32'h0040);
        check("branch_misalign", 32'(err_misalign), 32'd1);
        fetch_commit(16'h3333, 16'hFFFE, 1'b0);
        check("pc_inc_wrap", 32'(pc_inc), 32'h0000);
        fetch_commit(16'h4444, 16'h0000, 1'b0);
        check("wrap_addr", 32'(mem_addr), 32'h0000);

        // Halt with odd pc_next must not flag misalign
        do_reset(2);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        fetch_commit(16'hF000, 16'h0033, 1'b1);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_no_misalign", 32'(err_misalign), 32'd0);
        req_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom), 16'($urandom), 1'($urandom), 1'b0, 16'($urandom));
            req_cnt += int'(mem_req);
        end
        check("halt_req_quiet", 32'(req_cnt), 32'd0);
        check("halt_instr_kept", 32'(instr_out), 32'hF000);
        do_reset(1);
        check("halt_reset_addr", 32'(mem_addr), 32'(RESET_PC));

        // Timeout
        req_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
            req_cnt += int'(mem_req);
        end
        check("to_req_cycles", 32'(req_cnt), 32'(TIMEOUT));
        check("to_err", 32'(err_timeout), 32'd1);
        check("to_halted", 32'(halted), 32'd1);

        // Reset mid-fetch with a late ack
        do_reset(1);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
        rst = 1'b1;
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        model_reset();
        compare_all();
        check("rmf_req_drop", 32'(mem_req), 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        check("rmf_restart_req", 32'(mem_req), 32'd1);
        check("rmf_restart_addr", 32'(mem_addr), 32'(RESET_PC));
        check("rmf_ack_ignored", 32'(instr_out), 32'h0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                logic [15:0] pn;
                int sel;
                sel = int'($urandom_range(0, 9));
                if (sel < 6)      pn = 16'(m_pc + 16'd2);
                else if (sel < 9) pn = 16'($urandom) & 16'hFFFE;
                else              pn = 16'($urandom);
                step($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
                     $urandom_range(0, 29) == 0, pn);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
